// File: rtl/qr_cordic_pkg.sv
// Shared types and fixed-point helpers for the 4x4 CORDIC QR scheduler.
// Feature macro used by the top: QR_Q_GEN_EN (Q-side identity injection).
package qr_cordic_pkg;

  localparam int unsigned QR_IN_W      = 8;
  localparam int unsigned QR_FRAC_BITS = 10;
  localparam int unsigned QR_DATA_W    = QR_IN_W + 2 + QR_FRAC_BITS;
  localparam int unsigned QR_ONE       = 1 << QR_FRAC_BITS;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_CAL    = 4'b0100,
    ST_OUTPUT = 4'b1000
  } state_t;

  // {2 sign copies, sample, FRAC_BITS zeros}
  function automatic logic [QR_DATA_W-1:0] sign_ext(input logic [QR_IN_W-1:0] x);
    return {{2{x[QR_IN_W-1]}}, x, {QR_FRAC_BITS{1'b0}}};
  endfunction

  function automatic bit params_ok(input int unsigned n, iw, fb, dw, qw,
                                   iter, qskew, cal);
    return (dw == iw + 2 + fb) && (qw >= fb + 2) &&
           (cal >= (n - 1) * iter + qskew + n);
  endfunction

endpackage

// File: rtl/qr_cordic_sched_input_buf.sv
// NxN sample buffer: column-major write by sample index, one row-select read
// port per column.
module qr_input_buf import qr_cordic_pkg::*; #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = QR_DATA_W,
  localparam int unsigned IW = $clog2(N * N),
  localparam int unsigned RW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [N*RW-1:0]         rd_row,
  output logic [N*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [N][N];
  logic [RW-1:0]         wr_row;
  logic [RW-1:0]         wr_col;

  always_comb begin
    wr_row = RW'(32'(wr_idx) % N);
    wr_col = RW'(32'(wr_idx) / N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_rd
    assign rd_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_row[j*RW +: RW]][j];
  end

endmodule

// File: rtl/qr_cordic_sched.sv
// Load/CAL/readout sequencer for the 4x4 CORDIC QR systolic array.
// Optional macro QR_Q_GEN_EN enables the Q-side identity injection schedule.
module qr_cordic_sched import qr_cordic_pkg::*; #(
  parameter int unsigned N                = 4,
  parameter int unsigned INPUT_DATA_WIDTH = QR_IN_W,
  parameter int unsigned FRAC_BITS        = QR_FRAC_BITS,
  parameter int unsigned DATA_WIDTH       = QR_DATA_W,
  parameter int unsigned Q_DATA_WIDTH     = 12,
  parameter int unsigned ITER_NUM         = 4,
  parameter int unsigned Q_SKEW           = 5,
  parameter int unsigned CAL_CYCLES       = 29,
  localparam int unsigned RW = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [INPUT_DATA_WIDTH-1:0] in,
  output logic                      in_ready,
  output logic [N-1:0]              arr_valid,
  output logic [N*DATA_WIDTH-1:0]   arr_aij,
  output logic [N-1:0]              q_valid,
  output logic [N*Q_DATA_WIDTH-1:0] q_aij,
  output logic                      res_rd_en,
  output logic [RW-1:0]             res_row,
  output logic [RW-1:0]             res_col,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IW    = $clog2(N * N);
  localparam int unsigned CNT_W = $clog2((CAL_CYCLES > N * N) ? CAL_CYCLES : N * N) + 1;

  if (!params_ok(N, INPUT_DATA_WIDTH, FRAC_BITS, DATA_WIDTH, Q_DATA_WIDTH,
                 ITER_NUM, Q_SKEW, CAL_CYCLES) ||
      INPUT_DATA_WIDTH != QR_IN_W || FRAC_BITS != QR_FRAC_BITS) begin : g_bad_params
    $error("qr_cordic_sched: illegal parameter combination");
  end

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 accept;
  logic [N-1:0]         arr_hit_n;
  logic [N*RW-1:0]      rd_row;
  logic [N*DATA_WIDTH-1:0] rd_data;
  logic [N*DATA_WIDTH-1:0] arr_aij_n;

  assign accept = in_valid && in_ready;

  qr_input_buf #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (IW'(cnt)),
    .wr_data (sign_ext(in)),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        state_n = ST_LOAD;
        cnt_n   = '0;
      end
      ST_LOAD: begin
        if (accept) begin
          if (cnt == CNT_W'(N * N - 1)) begin
            state_n = ST_CAL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_CAL: begin
        if (cnt == CNT_W'(CAL_CYCLES - 1)) begin
          state_n = ST_OUTPUT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (cnt == CNT_W'(N * N - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered, so the schedule is decoded from next-cycle state/count.
  always_comb begin
    arr_hit_n = '0;
    rd_row    = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (state_n == ST_CAL && cnt_n == CNT_W'(i * ITER_NUM + j)) begin
          arr_hit_n[j]        = 1'b1;
          rd_row[j*RW +: RW] = RW'(i);
        end
      end
    end
  end

  always_comb begin
    arr_aij_n = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (arr_hit_n[j]) arr_aij_n[j*DATA_WIDTH +: DATA_WIDTH] = rd_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      arr_valid <= '0;
      arr_aij   <= '0;
      res_rd_en <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      in_ready  <= (state_n == ST_LOAD);
      busy      <= (state_n == ST_LOAD && cnt_n != '0) ||
                   state_n == ST_CAL || state_n == ST_OUTPUT;
      arr_valid <= arr_hit_n;
      arr_aij   <= arr_aij_n;
      res_rd_en <= (state_n == ST_OUTPUT);
      res_row   <= (state_n == ST_OUTPUT) ? RW'(32'(cnt_n) / N) : '0;
      res_col   <= (state_n == ST_OUTPUT) ? RW'(32'(cnt_n) % N) : '0;
      done      <= (state_n == ST_OUTPUT) && (cnt_n == CNT_W'(N * N - 1));
    end
  end

`ifdef QR_Q_GEN_EN
  logic [N-1:0]              q_valid_n;
  logic [N*Q_DATA_WIDTH-1:0] q_aij_n;

  always_comb begin
    q_valid_n = '0;
    q_aij_n   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (state_n == ST_CAL && cnt_n == CNT_W'(i * ITER_NUM + Q_SKEW + k)) begin
          q_valid_n[k] = 1'b1;
          if (i == k) q_aij_n[k*Q_DATA_WIDTH +: Q_DATA_WIDTH] = Q_DATA_WIDTH'(QR_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= '0;
      q_aij   <= '0;
    end else begin
      q_valid <= q_valid_n;
      q_aij   <= q_aij_n;
    end
  end
`else
  assign q_valid = '0;
  assign q_aij   = '0;
`endif

endmodule

// File: tb/tb_qr_cordic_sched.sv
// Scoreboard bench for qr_cordic_sched: expected CAL/readout frames are queued
// when a matrix is fed and popped cycle by cycle against the DUT outputs.
`timescale 1ns/1ps
module tb_qr_cordic_sched;

  localparam int N    = 4;
  localparam int DW   = 20;
  localparam int QW   = 12;
  localparam int ITER = 4;
  localparam int QSK  = 5;
  localparam int CAL  = 29;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        din;
  logic              in_ready;
  logic [N-1:0]      arr_valid;
  logic [N*DW-1:0]   arr_aij;
  logic [N-1:0]      q_valid;
  logic [N*QW-1:0]   q_aij;
  logic              res_rd_en;
  logic [1:0]        res_row;
  logic [1:0]        res_col;
  logic              busy;
  logic              done;

  qr_cordic_sched #(
    .N(N), .INPUT_DATA_WIDTH(8), .FRAC_BITS(10), .DATA_WIDTH(DW),
    .Q_DATA_WIDTH(QW), .ITER_NUM(ITER), .Q_SKEW(QSK), .CAL_CYCLES(CAL)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .in_ready(in_ready),
    .arr_valid(arr_valid), .arr_aij(arr_aij), .q_valid(q_valid), .q_aij(q_aij),
    .res_rd_en(res_rd_en), .res_row(res_row), .res_col(res_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    av;
    logic [N*DW-1:0] ad;
    logic [N-1:0]    qv;
    logic [N*QW-1:0] qd;
  } cal_exp_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
    logic       dn;
  } rd_exp_t;

  cal_exp_t   cal_q[$];
  rd_exp_t    rd_q[$];
  logic [7:0] mat [N][N];
  logic [7:0] samp [N*N];
  int         total = 0;
  int         bad   = 0;

  task automatic push_expected();
    cal_exp_t e;
    rd_exp_t  r;
    for (int c = 0; c < CAL; c++) begin
      e = '0;
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          if (c == i * ITER + j) begin
            e.av[j] = 1'b1;
            e.ad[j*DW +: DW] = {{2{mat[i][j][7]}}, mat[i][j], 10'b0};
          end
`ifdef QR_Q_GEN_EN
          if (c == i * ITER + QSK + j) begin
            e.qv[j] = 1'b1;
            if (i == j) e.qd[j*QW +: QW] = 12'h400;
          end
`endif
        end
      end
      cal_q.push_back(e);
    end
    for (int o = 0; o < N * N; o++) begin
      r.row = 2'(o / N);
      r.col = 2'(o % N);
      r.dn  = (o == N * N - 1);
      rd_q.push_back(r);
    end
  endtask

  // Feeds samp[start .. start+count-1]; ends on the negedge after the last accept.
  task automatic feed(input int start, input int count, input int gap);
    int budget;
    for (int s = start; s < start + count; s++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      budget = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL in_ready_wait sample=%0d got=%b want=1", s, in_ready);
      end
      in_valid = 1'b1;
      din      = samp[s];
      mat[s % N][s / N] = samp[s];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_cal(input int pulse_c);
    cal_exp_t e;
    for (int c = 0; c < CAL; c++) begin
      total++;
      if (cal_q.size() == 0) begin
        bad++;
        $display("FAIL cal_queue_empty c=%0d got=0 want=1", c);
        break;
      end
      e = cal_q.pop_front();
      if ({arr_valid, arr_aij} !== {e.av, e.ad}) begin
        bad++;
        $display("FAIL arr c=%0d got=%h/%h want=%h/%h", c, arr_valid, arr_aij, e.av, e.ad);
      end
      total++;
      if ({q_valid, q_aij} !== {e.qv, e.qd}) begin
        bad++;
        $display("FAIL q c=%0d got=%h/%h want=%h/%h", c, q_valid, q_aij, e.qv, e.qd);
      end
      total++;
      if ({busy, in_ready, res_rd_en, done} !== 4'b1000) begin
        bad++;
        $display("FAIL cal_ctrl c=%0d got=%b want=1000", c, {busy, in_ready, res_rd_en, done});
      end
      if (c == pulse_c) begin
        in_valid = 1'b1;
        din      = 8'h5A;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_out();
    rd_exp_t r;
    for (int o = 0; o < N * N; o++) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_queue_empty o=%0d got=0 want=1", o);
        break;
      end
      r = rd_q.pop_front();
      if ({res_rd_en, res_row, res_col, done, busy, arr_valid} !== {1'b1, r.row, r.col, r.dn, 1'b1, 4'b0}) begin
        bad++;
        $display("FAIL readout o=%0d got=%b/%0d/%0d/%b want=1/%0d/%0d/%b", o,
                 res_rd_en, res_row, res_col, done, r.row, r.col, r.dn);
      end
      @(negedge clk);
    end
    total++;
    if ({res_rd_en, done, busy, in_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_out got=%b want=0000", {res_rd_en, done, busy, in_ready});
    end
    @(negedge clk);
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL load_after_idle got=%b want=10", {in_ready, busy});
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({in_ready, arr_valid, arr_aij, q_valid, q_aij, res_rd_en, res_row, res_col, busy, done} !== '0) begin
      bad++;
      $display("FAIL %s got=%b/%h/%h/%h/%b/%b want=all_zero", tag, in_ready, arr_valid,
               arr_aij, q_valid, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    #1;
    check_all_zero("idle_after_release");
    @(negedge clk);
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL load_entry got=%b want=10", {in_ready, busy});
    end
  endtask

  task automatic test_continuous();
    for (int s = 0; s < N * N; s++) samp[s] = 8'(s + 1);
    feed(0, N * N, 0);
    push_expected();
    check_cal(-1);
    check_out();
  endtask

  task automatic test_negative();
    for (int s = 0; s < N * N; s++) samp[s] = 8'($urandom_range(0, 255));
    samp[0] = 8'h80;
    feed(0, N * N, 0);
    total++;
    if ({arr_valid[0], arr_aij[DW-1:0]} !== {1'b1, 20'hE0000}) begin
      bad++;
      $display("FAIL neg_sign_ext got=%b/%h want=1/e0000", arr_valid[0], arr_aij[DW-1:0]);
    end
    push_expected();
    check_cal(-1);
    check_out();
  endtask

  task automatic test_gaps();
    for (int s = 0; s < N * N; s++) samp[s] = 8'(s + 1);
    feed(0, N * N, 3);
    push_expected();
    check_cal(2);
    check_out();
  endtask

  task automatic test_mid_reset();
    for (int s = 0; s < N * N; s++) samp[s] = 8'($urandom_range(0, 255));
    feed(0, N * N, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    cal_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < N * N; s++) samp[s] = 8'($urandom_range(0, 255));
    feed(0, N * N - 1, 0);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({in_ready, busy, arr_valid, res_rd_en} !== {2'b11, 4'b0, 1'b0}) begin
        bad++;
        $display("FAIL partial_matrix_hold k=%0d got=%b want=1100000", k,
                 {in_ready, busy, arr_valid, res_rd_en});
      end
      @(negedge clk);
    end
    feed(N * N - 1, 1, 0);
    push_expected();
    check_cal(-1);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_continuous();
    test_negative();
    test_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
